// File: rtl/pcie_read_mod_pkg.sv
// pcie_read_mod_pkg: shared mailbox constants, FSM state type and helpers for the host-to-FPGA read path.
//   NTHREAD          number of simulated cores/threads (default NCORE of pcie_read_mod)
//   MBOX_SLOT_SHIFT  log2 of the per-core RAM slot size in 32-bit words
//   WIDX_HDR/WIDX_LO word index of the header word and of the lowest body word
//   LEAD_BIT         toggling new-message bit inside the header word
//   Optional macro PCIE_READ_RECHECK_EN adds the RECHECK/WAIT_RCHK states.
package pcie_read_mod_pkg;
    localparam int NTHREAD = 1;
    localparam int MBOX_SLOT_SHIFT = 5;
    localparam logic [2:0] WIDX_HDR = 3'd4;
    localparam logic [2:0] WIDX_LO = 3'd1;
    localparam int LEAD_BIT = 31;
    typedef enum logic [3:0] {
        IDLE,
        RD_HDR,
        WAIT_HDR,
        RD_BODY,
        WAIT_BODY,
`ifdef PCIE_READ_RECHECK_EN
        RECHECK,
        WAIT_RCHK,
`endif
        PRESENT,
        NEXT
    } rd_state_t;
    function automatic int core_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pcie_read_mod_rr_ptr.sv
// pcie_mbox_rr_ptr: round-robin mailbox pointer with wrap and the inter-sweep POLL_GAP counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   advance     step to the next mailbox (reloads the gap counter on wrap)
//   core        current mailbox index
//   wrap        current mailbox is the last one of the sweep
//   gap_done    gap counter has expired
module pcie_mbox_rr_ptr
    import pcie_read_mod_pkg::*;
#(
    parameter int NCORE = 1,
    parameter int POLL_GAP = 8,
    localparam int CORE_W = core_w(NCORE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    output logic [CORE_W-1:0] core,
    output logic              wrap,
    output logic              gap_done
);
    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    logic [GAP_W-1:0] gap;
    assign wrap = (core == CORE_W'(NCORE - 1));
    assign gap_done = (gap == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core <= '0;
            gap <= '0;
        end else begin
            if (advance)
                core <= wrap ? '0 : core + 1'b1;
            gap <= (advance && wrap) ? GAP_W'(POLL_GAP) : gap_done ? gap : gap - 1'b1;
        end
    end
endmodule

// File: rtl/pcie_read_mod.sv
// pcie_read_mod: polls per-core host-to-FPGA mailboxes in PCIe BRAM and hands new 128-bit messages to the core.
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        polling enable (an in-flight message always completes)
//   RAM_busy      RAM port owned by another master; reads wait while high
//   RAM_addr      read address (core<<5) + MBOX_OFS + widx, 0 when not reading
//   rd_en         read request
//   RAM_rdata     read data, one cycle after an accepted read
//   out_valid     assembled message available
//   out_ready     consumer accept
//   out_data      {w4,w3,w2,w1}, w4 = header word
//   out_core      mailbox index of out_data
//   Optional macro PCIE_READ_RECHECK_EN: re-read the header after the body and drop torn messages.
module pcie_read_mod
    import pcie_read_mod_pkg::*;
#(
    parameter int NCORE = NTHREAD,
    parameter int MBOX_OFS = 16,
    parameter int POLL_GAP = 8,
    localparam int CORE_W = core_w(NCORE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              RAM_busy,
    output logic [10:0]       RAM_addr,
    output logic              rd_en,
    input  logic [31:0]       RAM_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic [CORE_W-1:0] out_core
);
    rd_state_t state, nxt;
    logic [2:0] widx;
    logic [NCORE-1:0] exp_lead;
    logic [CORE_W-1:0] core;
    logic wrap, gap_done, lead_new;
    logic [127:0] data;
    logic [6:0] slot;
    pcie_mbox_rr_ptr #(.NCORE(NCORE), .POLL_GAP(POLL_GAP)) u_ptr (
        .clk(clk),
        .rst_n(rst_n),
        .advance(state == NEXT),
        .core(core),
        .wrap(wrap),
        .gap_done(gap_done)
    );
    // A message is new when its lead bit differs from the last one consumed for this core.
    assign lead_new = RAM_rdata[LEAD_BIT] != exp_lead[core];
    assign slot = {2'(widx - 3'd1), 5'd0};
    assign RAM_addr = rd_en ? (11'(core) << MBOX_SLOT_SHIFT) + 11'(MBOX_OFS) + 11'(widx) : '0;
    assign out_valid = (state == PRESENT);
    assign out_data = data;
    assign out_core = core;
    always_comb begin
        nxt = state;
        rd_en = 1'b0;
        case (state)
            IDLE:      nxt = (gap_done && enable) ? RD_HDR : IDLE;
            RD_HDR:    begin rd_en = 1'b1; nxt = RAM_busy ? RD_HDR : WAIT_HDR; end
            WAIT_HDR:  nxt = lead_new ? RD_BODY : NEXT;
            RD_BODY:   begin rd_en = 1'b1; nxt = RAM_busy ? RD_BODY : WAIT_BODY; end
`ifdef PCIE_READ_RECHECK_EN
            WAIT_BODY: nxt = (widx == WIDX_LO) ? RECHECK : RD_BODY;
            RECHECK:   begin rd_en = 1'b1; nxt = RAM_busy ? RECHECK : WAIT_RCHK; end
            // A changed header means the host rewrote the mailbox mid-fetch: refetch this core.
            WAIT_RCHK: nxt = (RAM_rdata == data[127:96]) ? PRESENT : RD_HDR;
`else
            WAIT_BODY: nxt = (widx == WIDX_LO) ? PRESENT : RD_BODY;
`endif
            PRESENT:   nxt = out_ready ? NEXT : PRESENT;
            NEXT:      nxt = (!wrap && enable) ? RD_HDR : IDLE;
            default:   nxt = IDLE;
        endcase
    end
    // widx returns to the header index whenever a fetch ends, so every RD_HDR/RECHECK reads word 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            widx <= WIDX_HDR;
            exp_lead <= '0;
            data <= '0;
        end else begin
            state <= nxt;
            if (state == WAIT_HDR) begin
                data[127:96] <= RAM_rdata;
                widx <= lead_new ? WIDX_HDR - 3'd1 : WIDX_HDR;
            end
            if (state == WAIT_BODY) begin
                data[slot +: 32] <= RAM_rdata;
                widx <= (widx == WIDX_LO) ? WIDX_HDR : widx - 3'd1;
            end
            if (state == PRESENT && out_ready)
                exp_lead[core] <= ~exp_lead[core];
        end
    end
    ncore_max: assert property (@(posedge clk) NCORE <= 64);
endmodule

// File: tb/tb_pcie_read_mod.sv
// tb_pcie_read_mod: scoreboard bench for pcie_read_mod with a BRAM model and a mailbox-level reference model.
module tb_pcie_read_mod;
    localparam int NC = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic RAM_busy = 1'b0;
    logic out_ready = 1'b0;
    logic [10:0] RAM_addr;
    logic rd_en;
    logic [31:0] RAM_rdata = '0;
    logic out_valid;
    logic [127:0] out_data;
    logic out_core;
    logic [31:0] mem [0:2047];
    logic [127:0] exp_q [NC][$];
    logic mlead [NC];
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    logic hold = 1'b0;
    logic [127:0] hd;
    logic hc;
    logic [127:0] last_acc = '0;

    pcie_read_mod #(.NCORE(NC), .MBOX_OFS(16), .POLL_GAP(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .RAM_busy(RAM_busy),
        .RAM_addr(RAM_addr),
        .rd_en(rd_en),
        .RAM_rdata(RAM_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_core(out_core)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rd_en && !RAM_busy) RAM_rdata <= mem[RAM_addr];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: a mailbox holds a message when its header lead bit differs from the lead last consumed.
    task automatic sync_core(input int c);
        if (mem[c*32+20][31] != mlead[c]) begin
            exp_q[c].push_back({mem[c*32+20], mem[c*32+19], mem[c*32+18], mem[c*32+17]});
            mlead[c] = mem[c*32+20][31];
        end
    endtask

    task automatic host_write(input int c, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [31:0] w4);
        mem[c*32+17] = w1;
        mem[c*32+18] = w2;
        mem[c*32+19] = w3;
        mem[c*32+20] = w4;
        sync_core(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [10:0] a, input string nm);
        int n = 0;
        while (!(rd_en && RAM_addr == a) && n < 500) begin
            cyc();
            n++;
        end
        chk(nm, 128'(rd_en && RAM_addr == a), 128'd1);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 3000) begin
            cyc();
            n++;
        end
        chk(nm, 128'(exp_q[0].size() + exp_q[1].size()), 128'd0);
    endtask

    always @(negedge clk) begin
        int c;
        logic [127:0] e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold && !out_valid) chk("valid_dropped_before_accept", 128'(out_valid), 128'd1);
            if (hold && out_valid) begin
                chk("hold_data_stable", out_data, hd);
                chk("hold_core_stable", 128'(out_core), 128'(hc));
            end
            hold = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    c = int'(out_core);
                    n_acc++;
                    last_acc = out_data;
                    if (exp_q[c].size() == 0) begin
                        chk("unexpected_msg", 128'd1, 128'd0);
                    end else begin
                        e = exp_q[c].pop_front();
                        chk("msg_data", out_data, e);
                    end
                end else begin
                    hold = 1'b1;
                    hd = out_data;
                    hc = out_core;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last52, gapmin, a0;
        logic saw, bad, ok, okr, c;
        logic [127:0] d;
        logic [31:0] w4;
`ifdef PCIE_READ_RECHECK_EN
        logic [127:0] e;
`endif
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        for (int i = 0; i < NC; i++) mlead[i] = 1'b0;
        repeat (3) cyc();
        chk("rst_rd_en", 128'(rd_en), 128'd0);
        chk("rst_addr", 128'(RAM_addr), 128'd0);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_core", 128'(out_core), 128'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        // Poll sweep with empty mailboxes.
        last52 = -1;
        gapmin = 1000;
        saw = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (out_valid) saw = 1'b1;
            if (rd_en) begin
                if (RAM_addr != 11'd20 && RAM_addr != 11'd52) bad = 1'b1;
                if (RAM_addr == 11'd52) last52 = k;
                else if (last52 >= 0 && k - last52 - 1 < gapmin) gapmin = k - last52 - 1;
            end
        end
        chk("poll_hdr_addr_only", 128'(bad), 128'd0);
        chk("poll_no_valid", 128'(saw), 128'd0);
        chk("poll_gap_ge8", 128'(gapmin >= 8 && gapmin < 1000), 128'd1);
        // Polling disabled.
        enable = 1'b0;
        repeat (10) cyc();
        saw = 1'b0;
        repeat (40) begin
            cyc();
            if (rd_en) saw = 1'b1;
        end
        chk("enable_low_no_read", 128'(saw), 128'd0);
        enable = 1'b1;
        // Single message on core 0, minimum latency.
        host_write(0, 32'h11111111, 32'h22222222, 32'h33333333, 32'hC4444444);
        wait_addr(11'd20, "msg1_hdr_read");
        n = 0;
        while (!out_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("msg1_latency", 128'(n), 128'd8);
        chk("msg1_data", out_data, 128'hC4444444_33333333_22222222_11111111);
        wait_drain("msg1_drain");
        // Body rewritten, header lead unchanged.
        a0 = n_acc;
        host_write(0, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hC4444444);
        repeat (80) cyc();
        chk("repeat_no_msg", 128'(n_acc - a0), 128'd0);
        // Backpressure on core 1.
        out_ready = 1'b0;
        host_write(1, 32'h01010101, 32'h02020202, 32'h03030303, 32'h90000001);
        n = 0;
        while (!out_valid && n < 200) begin
            cyc();
            n++;
        end
        chk("bp_valid", 128'(out_valid), 128'd1);
        chk("bp_data", out_data, 128'h90000001_03030303_02020202_01010101);
        d = out_data;
        ok = 1'b1;
        okr = 1'b1;
        repeat (20) begin
            cyc();
            if (out_data !== d || !out_valid) ok = 1'b0;
            if (rd_en) okr = 1'b0;
        end
        chk("bp_stable", 128'(ok), 128'd1);
        chk("bp_no_read", 128'(okr), 128'd1);
        out_ready = 1'b1;
        wait_drain("bp_drain");
        // RAM busy during widx=2 of core 0.
        host_write(0, 32'h000000A1, 32'h000000A2, 32'h000000A3, 32'h400000AA);
        wait_addr(11'd18, "busy_addr18");
        RAM_busy = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            cyc();
            if (!(rd_en && RAM_addr == 11'd18)) ok = 1'b0;
        end
        chk("busy_hold", 128'(ok), 128'd1);
        RAM_busy = 1'b0;
        wait_drain("busy_drain");
        // Asynchronous reset during WAIT_BODY of core 1.
        host_write(1, 32'h5, 32'h6, 32'h7, 32'h00001234);
        wait_addr(11'd51, "rst_body_read");
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", 128'(rd_en), 128'd0);
        chk("arst_addr", 128'(RAM_addr), 128'd0);
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_data", out_data, 128'd0);
        chk("arst_core", 128'(out_core), 128'd0);
        for (int i = 0; i < NC; i++) begin
            exp_q[i].delete();
            mlead[i] = 1'b0;
        end
        for (int i = 0; i < NC; i++) sync_core(i);
        cyc();
        rst_n = 1'b1;
        n = 0;
        while (!rd_en && n < 50) begin
            cyc();
            n++;
        end
        chk("arst_restart_core0", 128'(RAM_addr), 128'd20);
        a0 = n_acc;
        repeat (60) cyc();
        chk("arst_quiet", 128'(n_acc - a0), 128'd0);
`ifdef PCIE_READ_RECHECK_EN
        // Header rewritten between the first header read and the recheck.
        host_write(0, 32'h00000111, 32'h00000222, 32'h00000333, 32'h80000001);
        wait_addr(11'd17, "rchk_w1_read");
        mem[20] = 32'h80000002;
        e = exp_q[0].pop_front();
        e[127:96] = 32'h80000002;
        exp_q[0].push_back(e);
        wait_drain("rchk_drain");
        chk("rchk_final_hdr", 128'(last_acc[127:96]), 128'h80000002);
`endif
        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            cyc();
            RAM_busy = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                c = 1'($urandom_range(0, NC - 1));
                if (exp_q[c].size() == 0) begin
                    w4 = $urandom;
                    w4[31] = ($urandom_range(0, 3) != 0) ? ~mlead[c] : mlead[c];
                    host_write(int'(c), $urandom, $urandom, $urandom, w4);
                end
            end
        end
        enable = 1'b1;
        RAM_busy = 1'b0;
        out_ready = 1'b1;
        wait_drain("final_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
